booth_seq_multiplier: RTL and testbench

- Sequential signed multiplier (radix-2 Booth) that sequences one shared N+1-bit add/sub unit, the team's sign-extending ripple adder with a subtract-select input, over N iterations.
- Accepts a start pulse with two N-bit two's-complement operands and returns a 2N-bit signed product with a one-cycle done pulse.
- Sits between a simple requester (ALU/lab top level) and the existing add/sub datapath.

---
 rtl/booth_seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential signed multiplier: one shared add/sub unit, N iterations, done pulse N+1 cycles after start.
// No backpressure: start is honoured only in IDLE; the product is held in p until the next accepted start.
module addsub_ripple #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W:0]   carry;
  logic [W-1:0] y_sel;

  // Subtract is x + ~y + 1, with the +1 entering as the ripple carry-in.
  assign carry[0] = sub;
  assign y_sel    = y ^ {W{sub}};

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]     = x[i] ^ y_sel[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y_sel[i]) | (carry[i] & (x[i] ^ y_sel[i]));
  end
endmodule

module booth_seq_multiplier #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] p_q, p_d;

  logic           sub_sel;
  logic [N:0]     addsub_sum;
  logic [N:0]     acc_nx;
  logic [N:0]     acc_sh;
  logic [N-1:0]   q_sh;
  logic           q1_sh;

  addsub_ripple #(.W(N + 1)) u_addsub (
    .x   (acc_q),
    .y   (m_q),
    .sub (sub_sel),
    .sum (addsub_sum)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;

    // {Q[0],Q_1}: 10 subtracts M, 01 adds M, 00/11 keep ACC.
    sub_sel = q_q[0] & ~q1_q;
    acc_nx  = (q_q[0] ^ q1_q) ? addsub_sum : acc_q;
    {acc_sh, q_sh, q1_sh} = {acc_nx[N], acc_nx, q_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {a[N-1], a};
          acc_d   = '0;
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          p_d     = {acc_sh[N-1:0], q_sh};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: N=4 and N=8 instances, scoreboard queues popped by per-DUT done monitors.
module tb_booth_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int n_checks = 0;
  int n_pass   = 0;
  int push4_cnt = 0, done4_cnt = 0;
  int push8_cnt = 0, done8_cnt = 0;
  logic [15:0] exp4_q[$];
  logic [15:0] exp8_q[$];

  always #5 clk = ~clk;

  booth_seq_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  booth_seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitors: every done pops one expected product.
  always @(negedge clk) begin
    if (done4) begin
      done4_cnt++;
      if (exp4_q.size() == 0) check("unexpected done4", {15'b0, done4}, 16'h0);
      else check("p4", {8'h00, p4}, exp4_q.pop_front());
    end
    if (done8) begin
      done8_cnt++;
      if (exp8_q.size() == 0) check("unexpected done8", {15'b0, done8}, 16'h0);
      else check("p8", p8, exp8_q.pop_front());
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int lat, bcnt;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = a; b4 = b;
    exp4_q.push_back({8'h00, exp});
    push4_cnt++;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy4) bcnt++;
      if (done4) break;
    end
    check("latency4", 16'(lat), 16'd5);
    check("busy4 cycles", 16'(bcnt), 16'd4);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int lat, bcnt;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b;
    exp8_q.push_back(exp);
    push8_cnt++;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
      if (done8) break;
    end
    check("latency8", 16'(lat), 16'd9);
    check("busy8 cycles", 16'(bcnt), 16'd8);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done4) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held, n1, n2;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("reset busy4", {15'b0, busy4}, 16'h0);
    check("reset done4", {15'b0, done4}, 16'h0);
    check("reset p4", {8'h00, p4}, 16'h0);
    check("reset busy8", {15'b0, busy8}, 16'h0);
    check("reset p8", p8, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product and hold.
    op4(4'd3, 4'd5, 8'h0F);
    held = 0;
    repeat (10) begin
      @(negedge clk);
      if (p4 === 8'h0F && !busy4 && !done4) held++;
    end
    check("p4 held cycles", 16'(held), 16'd10);

    // Sign corners.
    op4(4'h8, 4'h8, 8'h40);
    op4(4'h8, 4'h7, 8'hC8);
    op4(4'h7, 4'hF, 8'hF9);
    op4(4'h0, 4'hB, 8'h00);

    // Exhaustive, back-to-back.
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        op4(4'(i), 4'(j), 8'(i * j));
      end
    end

    // start held high; operands changed mid-run must not leak in.
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd3;
    exp4_q.push_back(16'h0006); push4_cnt++;
    @(posedge clk); #1;
    a4 = 4'd5; b4 = 4'd5;
    exp4_q.push_back(16'h0019); push4_cnt++;
    wait_done4(n1);
    check("held-start latency", 16'(n1), 16'd5);
    wait_done4(n2);
    start4 = 1'b0;
    check("held-start interval", 16'(n2), 16'd6);

    // Asynchronous reset in the 2nd RUN cycle discards the operation.
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'hD; b4 = 4'h6;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrun reset busy4", {15'b0, busy4}, 16'h0);
    check("midrun reset done4", {15'b0, done4}, 16'h0);
    check("midrun reset p4", {8'h00, p4}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    op4(4'hD, 4'h6, 8'hEE);

    // N=8 instance.
    op8(8'h80, 8'h80, 16'h4000);
    op8(8'h7F, 8'h80, 16'hC080);

    repeat (5) @(negedge clk);
    check("queue4 empty", 16'(exp4_q.size()), 16'd0);
    check("queue8 empty", 16'(exp8_q.size()), 16'd0);
    check("done4 count", 16'(done4_cnt), 16'(push4_cnt));
    check("done8 count", 16'(done8_cnt), 16'(push8_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
